// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file read ports, the stall
// control and the iterative multiply/divide unit.
interface mul_div_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO: 32 shift-add or restoring
// divide iterations on magnitudes, then a sign-fix cycle; MTHI/MTLO while idle.
module mul_div_unit (
   input  logic         clk,
   input  logic         rst,
   mul_div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        div_q, div_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        dz_q, dz_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;

   function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [31:0] neg32(input logic signed [31:0] v, input logic neg);
      return neg ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [63:0] neg64(input logic signed [63:0] v, input logic neg);
      return neg ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Multiply step: conditionally add the multiplicand into the upper half.
   logic [32:0] mul_sum;
   logic [32:0] mul_add;
   assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
   assign mul_add = acc_q[0] ? mul_sum : {1'b0, acc_q[63:32]};

   // Divide step: trial[32] is set exactly when the divisor does not fit.
   logic [32:0] div_part;
   logic [32:0] div_trial;
   logic        div_restore;
   logic [31:0] rem_next;
   assign div_part    = {acc_q[63:32], acc_q[31]};
   assign div_trial   = div_part - {1'b0, opnd_q};
   assign div_restore = div_trial[32];
   assign rem_next    = div_restore ? div_part[31:0] : div_trial[31:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      case (state_q)
         IDLE: begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
            if (bus.start) begin
               div_d = bus.op[1];
               sa_d  = bus.op[0] & bus.a[31];
               sb_d  = bus.op[0] & bus.b[31];
               dz_d  = (bus.b == 32'd0);
               if (bus.op[1]) begin
                  acc_d  = {32'd0, mag32(bus.a, bus.op[0])};
                  opnd_d = mag32(bus.b, bus.op[0]);
               end else begin
                  acc_d  = {32'd0, mag32(bus.b, bus.op[0])};
                  opnd_d = mag32(bus.a, bus.op[0]);
               end
               cnt_d   = 5'd31;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (div_q) acc_d = {rem_next, acc_q[30:0], ~div_restore};
            else       acc_d = {mul_add, acc_q[31:1]};
            if (cnt_q == 5'd0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         FIX: begin
            // Divide by zero keeps the all-ones quotient regardless of signs.
            if (div_q) begin
               lo_d = dz_q ? 32'hFFFF_FFFF : neg32(acc_q[31:0], sa_q ^ sb_q);
               hi_d = neg32(acc_q[63:32], sa_q);
            end else begin
               {hi_d, lo_d} = neg64(acc_q, sa_q ^ sb_q);
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      div_q  <= div_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      dz_q   <= dz_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, signed/unsigned results,
// divide corner cases, busy-time filtering, MTHI/MTLO and async reset.
module tb_mul_div_unit;

   logic clk = 1'b0;
   logic rst;
   mul_div_unit_if bus ();

   mul_div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents an operation for one edge (E0); returns 1 time unit after E0.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      step(1);
      bus.start = 1'b0;
      bus.a     = 32'h5A5A_5A5A;
      bus.b     = 32'hC3C3_C3C3;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = 32'd0;
      step(2);
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want %h", bus.hi, 32'd0); end
      vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want %h", bus.lo, 32'd0); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_multu_latency();
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL multu_busy_e0 got %b want 1", bus.busy); end
      step(32);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL multu_busy_e32 got %b want 1", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_e32 got %b want 0", bus.done); end
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL multu_hi_held got %h want %h", bus.hi, 32'd0); end
      step(1);
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL multu_done_e33 got %b want 1", bus.done); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_e33 got %b want 0", bus.busy); end
      vectors++; if (bus.hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want %h", bus.hi, 32'hFFFF_FFFE); end
      vectors++; if (bus.lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want %h", bus.lo, 32'h0000_0001); end
      step(1);
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_e34 got %b want 0", bus.done); end
   endtask

   task automatic test_mult_signed();
      issue(2'b01, 32'hFFFF_FFFD, 32'd5);
      step(33);
      vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_neg_hi got %h want %h", bus.hi, 32'hFFFF_FFFF); end
      vectors++; if (bus.lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL mult_neg_lo got %h want %h", bus.lo, 32'hFFFF_FFF1); end
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      step(33);
      vectors++; if (bus.hi !== 32'h0000_0004) begin miscompares++; $display("FAIL multu_mixed_hi got %h want %h", bus.hi, 32'h0000_0004); end
      vectors++; if (bus.lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL multu_mixed_lo got %h want %h", bus.lo, 32'hFFFF_FFF1); end
      issue(2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
      step(33);
      vectors++; if (bus.hi !== 32'h0000_0000) begin miscompares++; $display("FAIL mult_negneg_hi got %h want %h", bus.hi, 32'h0000_0000); end
      vectors++; if (bus.lo !== 32'h0000_002A) begin miscompares++; $display("FAIL mult_negneg_lo got %h want %h", bus.lo, 32'h0000_002A); end
   endtask

   task automatic test_divide();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      step(33);
      vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_lo got %h want %h", bus.lo, 32'hFFFF_FFFD); end
      vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_hi got %h want %h", bus.hi, 32'hFFFF_FFFF); end
      issue(2'b10, 32'd100, 32'd7);
      step(33);
      vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %h want %h", bus.lo, 32'd14); end
      vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %h want %h", bus.hi, 32'd2); end
      issue(2'b10, 32'h0000_1234, 32'd0);
      step(33);
      vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu_zero_lo got %h want %h", bus.lo, 32'hFFFF_FFFF); end
      vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL divu_zero_hi got %h want %h", bus.hi, 32'h0000_1234); end
      issue(2'b11, 32'hFFFF_FFF9, 32'd0);
      step(33);
      vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_zero_lo got %h want %h", bus.lo, 32'hFFFF_FFFF); end
      vectors++; if (bus.hi !== 32'hFFFF_FFF9) begin miscompares++; $display("FAIL div_zero_hi got %h want %h", bus.hi, 32'hFFFF_FFF9); end
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      step(33);
      vectors++; if (bus.lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_wrap_lo got %h want %h", bus.lo, 32'h8000_0000); end
      vectors++; if (bus.hi !== 32'h0000_0000) begin miscompares++; $display("FAIL div_wrap_hi got %h want %h", bus.hi, 32'h0000_0000); end
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL div_wrap_done got %b want 1", bus.done); end
   endtask

   task automatic test_busy_ignore();
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h1111_2222;
      step(1);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      vectors++; if (bus.hi !== 32'h1111_2222) begin miscompares++; $display("FAIL mt_both_hi got %h want %h", bus.hi, 32'h1111_2222); end
      vectors++; if (bus.lo !== 32'h1111_2222) begin miscompares++; $display("FAIL mt_both_lo got %h want %h", bus.lo, 32'h1111_2222); end
      issue(2'b00, 32'd6, 32'd7);
      step(9);
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.a     = 32'd99;
      bus.b     = 32'd3;
      step(1);
      bus.start = 1'b0;
      step(1);
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      step(1);
      bus.hi_we = 1'b0;
      vectors++; if (bus.hi !== 32'h1111_2222) begin miscompares++; $display("FAIL busy_mthi got %h want %h", bus.hi, 32'h1111_2222); end
      step(21);
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL busy_done got %b want 1", bus.done); end
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL busy_hi got %h want %h", bus.hi, 32'd0); end
      vectors++; if (bus.lo !== 32'd42) begin miscompares++; $display("FAIL busy_lo got %h want %h", bus.lo, 32'd42); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_clear got %b want 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      issue(2'b10, 32'd100, 32'd7);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_low got %b want 0", bus.done); end
      step(33);
      vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL b2b_lo got %h want %h", bus.lo, 32'd14); end
      vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL b2b_hi got %h want %h", bus.hi, 32'd2); end
      step(1);
   endtask

   task automatic test_write_with_start();
      bus.hi_we = 1'b1;
      bus.wdata = 32'hCAFE_F00D;
      issue(2'b00, 32'd3, 32'd4);
      bus.hi_we = 1'b0;
      vectors++; if (bus.hi !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL wstart_hi_now got %h want %h", bus.hi, 32'hCAFE_F00D); end
      step(33);
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL wstart_hi_final got %h want %h", bus.hi, 32'd0); end
      vectors++; if (bus.lo !== 32'd12) begin miscompares++; $display("FAIL wstart_lo_final got %h want %h", bus.lo, 32'd12); end
      step(1);
   endtask

   task automatic test_reset_mid_op();
      logic seen_done;
      issue(2'b01, 32'hFFFF_FFFD, 32'd5);
      step(14);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_before got %b want 1", bus.busy); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL rmid_hi got %h want %h", bus.hi, 32'd0); end
      vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL rmid_lo got %h want %h", bus.lo, 32'd0); end
      step(1);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL rmid_no_done got %b want 0", seen_done); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_idle got %b want 0", bus.busy); end
      bus.lo_we = 1'b1;
      bus.wdata = 32'hA5A5_A5A5;
      step(1);
      bus.lo_we = 1'b0;
      vectors++; if (bus.lo !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL mtlo_lo got %h want %h", bus.lo, 32'hA5A5_A5A5); end
      vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL mtlo_hi got %h want %h", bus.hi, 32'd0); end
   endtask

   initial begin
      test_reset();
      test_multu_latency();
      test_mult_signed();
      test_divide();
      test_busy_ignore();
      test_back_to_back();
      test_write_with_start();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the single-clock CPU datapath. It sits directly downstream of the register file and consumes its two read-data operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles into internal HI/LO registers, and supports MTHI/MTLO writes. The control path stalls the pipeline while `busy` is high.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge only while idle.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a`  in  32  operand rs (register-file read data 1); sampled with `start`.
- `b`  in  32  operand rt (register-file read data 2); sampled with `start`.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; the pipeline stalls while high.
- `done`  out  1  one-cycle pulse when HI/LO receive a new result.
- `hi`  out  32  HI register (MFHI source).
- `lo`  out  32  LO register (MFLO source).
- One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 latches `op`, `a`, `b` and the operand signs.
  - Latched operands are converted to magnitudes when `op[0]`=1 (signed).
  - Loads a 5-bit counter with 31 and goes to CALC.
- **CALC**
  - One iteration per cycle.
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring divide, one quotient bit per cycle, MSB first; 33-bit trial subtract of the divisor from the partial remainder.
  - The counter decrements each cycle; at 0 the state goes to FIX.
- **FIX**
  - Applies signs for signed ops:
    - product negated if `sa`^`sb`;
    - quotient negated if `sa`^`sb`;
    - remainder negated if `sa`.
  - Writes HI/LO and returns to IDLE.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU with `b`=0) is not trapped and completes in normal latency with LO = 0xFFFFFFFF and HI = `a` unmodified.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no exception).
- `start` while busy is ignored: no latch, no restart.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` at the clock edge only while idle; both may be asserted together.
  - Writes while busy are ignored.
  - `start` and a write in the same idle cycle: the write takes effect, and the operation later overwrites both HI and LO at FIX.
- Operands are captured at `start`; changes on `a`/`b` afterwards have no effect.

## Timing
- Reset values:
  - `hi` = 0, `lo` = 0.
  - `busy` = 0, `done` = 0.
  - State = IDLE, counter = 0.
- With `start` sampled at edge E0:
  - `busy` = 1 from after E0 through edge E33.
  - CALC occupies edges E1..E32; FIX completes at E33.
  - `hi`/`lo` take the new value after E33.
  - `done` = 1 for exactly the cycle following E33.
  - `busy` = 0 after E33.
- Latency is 33 cycles from `start` to result visible; all ops take the same time.
- A new `start` is accepted at E33+1 at the earliest (back-to-back gap of zero idle cycles beyond `done`).
- `hi`/`lo` are registered outputs. They hold their previous value during CALC and are never partially updated.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). The operation is lost, and no `done` is produced after release.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, one `done` pulse.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- `start` pulsed again at cycle 10 with different operands, plus `hi_we` at cycle 12 -> both ignored; original result at cycle 33. A second `start` at the `done` cycle is accepted.
- `rst` pulsed at cycle 15 of a MULT -> `busy`/`hi`/`lo` = 0 immediately; no `done` pulse follows. Then MTLO `wdata`=0xA5A5A5A5 in idle -> lo=0xA5A5A5A5 next cycle.
